serial_to_parallel: RTL and testbench
=====================================

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 SHALL have parameter: N, default 16, output word width in bits (multiple of 8, >= 16).
REQ-002 SHALL have parameter: TIMEOUT, default 1200000, inter-byte timeout in iCE_CLK cycles (>= 2).
REQ-003 SHALL have port: iCE_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: rx_valid  input  1  one-cycle strobe; a received byte is present on rx_byte.
REQ-006 SHALL have port: rx_byte  input  8  received byte, sampled only when rx_valid=1.
REQ-007 SHALL have port: word_ready  input  1  consumer accepts the word when high with word_valid.
REQ-008 SHALL have port: word_valid  output  1  word holds a complete assembled value.
REQ-009 SHALL have port: word  output  N  assembled word, first received byte in bits [N-1:N-8].
REQ-010 SHALL have port: overrun  output  1  one-cycle pulse; a completed word was dropped.
REQ-011 SHALL have port: timeout  output  1  one-cycle pulse; a partial word was discarded.

Function
REQ-012 SHALL assemble bytes MSB-first: assembly register shifts left 8 and inserts rx_byte at bits [7:0] per accepted byte.
REQ-013 SHALL use an FSM with states IDLE (0 bytes held) and COLLECT (1..N/8-1 bytes held).
REQ-014 SHALL move IDLE->COLLECT on rx_valid, and COLLECT->IDLE when the N/8-th byte is accepted.
REQ-015 SHALL, on acceptance of the N/8-th byte, load word and assert word_valid on the next cycle (latency 1 cycle from final rx_valid).
REQ-016 SHALL hold word and word_valid stable until a cycle with word_valid=1 and word_ready=1; word_valid then deasserts next cycle.
REQ-017 SHALL, when a word completes in the same cycle as a handshake, load the new word and keep word_valid=1 without a gap.
REQ-018 SHALL, when a word completes while word_valid=1 and word_ready=0, keep the old word, discard the new one, pulse overrun for one cycle, and return to IDLE.
REQ-019 SHALL continue accepting bytes into the assembly register while word_valid=1 (double buffering).
REQ-020 SHALL ignore rx_byte when rx_valid=0; word outputs SHALL not change except on load.
REQ-021 SHALL hold overrun and timeout low except for their single-cycle pulses.

Reset
REQ-022 SHALL, while rst_n=0, force word_valid=0, word=0, overrun=0, timeout=0, byte count 0, assembly register 0, timer 0, FSM IDLE, independent of iCE_CLK.
REQ-023 SHALL discard any partial or pending word on reset asserted mid-operation; first rx_valid after release starts a fresh word.

Configuration
REQ-024 SHALL implement, when S2P_TIMEOUT_EN is defined, a cycle counter that clears on every accepted byte and increments in COLLECT.
REQ-025 SHALL, with S2P_TIMEOUT_EN, on reaching TIMEOUT cycles without a byte in COLLECT, discard the partial word, pulse timeout, and return to IDLE.
REQ-026 SHALL, with S2P_TIMEOUT_EN, give an rx_valid in the expiry cycle priority: byte accepted, counter cleared, no timeout pulse.
REQ-027 SHALL, without S2P_TIMEOUT_EN, contain no timer, tie timeout to 0, and hold partial words indefinitely.

Verification
REQ-028 SHALL cover: N=16, word_ready=1, bytes 0xAB then 0xCD -> word=0xABCD, word_valid high exactly one cycle, one cycle after second rx_valid.
REQ-029 SHALL cover: N=16, word_ready=0, words 0x1234 then 0x5678 -> word stays 0x1234, overrun pulses once; raise word_ready -> word_valid low next cycle.
REQ-030 SHALL cover: N=16, handshake in the same cycle 0x9ABC completes after 0x1234 pending -> word becomes 0x9ABC, word_valid never drops, overrun=0.
REQ-031 SHALL cover: S2P_TIMEOUT_EN, TIMEOUT=16, byte 0x55 then 16 idle cycles -> timeout pulse, no word; then 0xAA, 0xBB -> word=0xAABB.
REQ-032 SHALL cover: N=16, rst_n low for 2 cycles after byte 0x77 -> all outputs 0; then 0x01, 0x02 -> word=0x0102.
REQ-033 SHALL cover: N=32, bytes 0xDE, 0xAD, 0xBE, 0xEF with 3 idle cycles between -> word=0xDEADBEEF, single word_valid.

Source files
------------

// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel
// Function : Packs received bytes MSB-first into an N-bit word behind a
//            valid/ready output buffer. Defining S2P_TIMEOUT_EN enables the
//            inter-byte timeout that discards stale partial words.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel #(
    parameter int N       = 16,
    parameter int TIMEOUT = 1200000
) (
    input  logic         iCE_CLK,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         word_ready,
    output logic         word_valid,
    output logic [N-1:0] word,
    output logic         overrun,
    output logic         timeout
);

    localparam int c_BYTES = N / 8;
    localparam int c_CNT_W = $clog2(c_BYTES);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    // Holds at most N/8-1 bytes; the final byte goes straight into word.
    logic [N-9:0]         r_shift;
    logic [N-1:0]         w_next_shift;
    logic                 w_last;
    logic                 w_can_load;

    assign w_next_shift = {r_shift, rx_byte};
    assign w_last       = (r_count == c_CNT_W'(c_BYTES - 1));
    assign w_can_load   = !word_valid || word_ready;

    if (N < 16 || (N % 8) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("serial_to_parallel: unsupported N or TIMEOUT");
    end

`ifdef S2P_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT);
    logic [c_TMR_W-1:0]   r_timer;
`endif

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_shift    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef S2P_TIMEOUT_EN
            r_timer    <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef S2P_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (rx_valid) begin
`ifdef S2P_TIMEOUT_EN
                r_timer <= '0;
`endif
                if (w_last) begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_shift <= '0;
                    // A handshake this cycle frees the buffer, so reload without a gap.
                    if (w_can_load) begin
                        word       <= w_next_shift;
                        word_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    r_state <= COLLECT;
                    r_count <= r_count + 1'b1;
                    r_shift <= w_next_shift[N-9:0];
                end
            end
`ifdef S2P_TIMEOUT_EN
            else if (r_state == COLLECT) begin
                if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_shift <= '0;
                    r_timer <= '0;
                    timeout <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
`endif
        end
    end

`ifndef S2P_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel
// Function : Directed and random stimulus for 16- and 32-bit instances,
//            compared every cycle against a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        ready16 = 1'b1;
    logic        ready32 = 1'b1;
    logic        valid16, valid32, ovr16, ovr32, to16, to32;
    logic [15:0] word16;
    logic [31:0] word32;

    int checks = 0;
    int errors = 0;

    // Reference state, index 0 = 16-bit instance, 1 = 32-bit instance
    logic [31:0] m_word [2];
    bit          m_valid[2];
    bit          m_ovr  [2];
    bit          m_to   [2];
    logic [7:0]  m_q0[$];
    logic [7:0]  m_q1[$];
    int          m_idle [2];

    always #5 clk = ~clk;

    serial_to_parallel #(.N(16), .TIMEOUT(TMO)) dut16 (
        .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .word_ready(ready16), .word_valid(valid16), .word(word16),
        .overrun(ovr16), .timeout(to16)
    );

    serial_to_parallel #(.N(32), .TIMEOUT(TMO)) dut32 (
        .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .word_ready(ready32), .word_valid(valid32), .word(word32),
        .overrun(ovr32), .timeout(to32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_word[k] = '0; m_valid[k] = 0; m_ovr[k] = 0; m_to[k] = 0; m_idle[k] = 0;
        end
        m_q0.delete();
        m_q1.delete();
    endtask

    // Word value of a byte list: first byte most significant.
    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] v = 0;
        foreach (q[i]) v = v * 256 + 32'(q[i]);
        return v;
    endfunction

    task automatic model_step(input int k, input bit v, input logic [7:0] b, input bit rdy);
        logic [7:0] q[$];
        int  nb = (k == 0) ? 2 : 4;
        bit  free = !m_valid[k] || rdy;
        q = (k == 0) ? m_q0 : m_q1;
        m_ovr[k] = 0;
        m_to[k]  = 0;
        if (m_valid[k] && rdy) m_valid[k] = 0;
        if (v) begin
            q.push_back(b);
            m_idle[k] = 0;
            if (q.size() == nb) begin
                if (free) begin
                    m_word[k]  = pack(q);
                    m_valid[k] = 1;
                end else begin
                    m_ovr[k] = 1;
                end
                q.delete();
            end
        end else if (q.size() > 0) begin
`ifdef S2P_TIMEOUT_EN
            m_idle[k]++;
            if (m_idle[k] == TMO) begin
                q.delete();
                m_idle[k] = 0;
                m_to[k] = 1;
            end
`endif
        end
        if (k == 0) m_q0 = q; else m_q1 = q;
    endtask

    task automatic compare_all();
        chk("valid16", 32'(valid16), 32'(m_valid[0]));
        chk("word16",  32'(word16),  m_word[0]);
        chk("ovr16",   32'(ovr16),   32'(m_ovr[0]));
        chk("to16",    32'(to16),    32'(m_to[0]));
        chk("valid32", 32'(valid32), 32'(m_valid[1]));
        chk("word32",  word32,       m_word[1]);
        chk("ovr32",   32'(ovr32),   32'(m_ovr[1]));
        chk("to32",    32'(to32),    32'(m_to[1]));
    endtask

    task automatic cycle(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = v ? b : 8'($urandom);
        model_step(0, v, rx_byte, ready16);
        model_step(1, v, rx_byte, ready32);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic 2-byte word with immediate acceptance
        cycle(1, 8'hAB);
        cycle(1, 8'hCD);
        chk("abcd_word", 32'(word16), 32'h0000ABCD);
        chk("abcd_valid", 32'(valid16), 32'd1);
        cycle(0, 8'h00);
        chk("abcd_drop", 32'(valid16), 32'd0);

        // Consumer stalled: second word is dropped with an overrun pulse
        ready16 = 1'b0;
        cycle(1, 8'h12);
        cycle(1, 8'h34);
        cycle(1, 8'h56);
        cycle(1, 8'h78);
        chk("ovr_pulse", 32'(ovr16), 32'd1);
        chk("ovr_keep", 32'(word16), 32'h00001234);
        cycle(0, 8'h00);
        ready16 = 1'b1;
        cycle(0, 8'h00);
        chk("ovr_release", 32'(valid16), 32'd0);

        // Completion coincides with handshake: no gap, no overrun
        ready16 = 1'b0;
        cycle(1, 8'h12);
        cycle(1, 8'h34);
        cycle(1, 8'h9A);
        ready16 = 1'b1;
        cycle(1, 8'hBC);
        chk("b2b_word", 32'(word16), 32'h00009ABC);
        chk("b2b_valid", 32'(valid16), 32'd1);
        chk("b2b_ovr", 32'(ovr16), 32'd0);
        cycle(0, 8'h00);

        // Partial word followed by a long silence
        do_reset();
        cycle(1, 8'h55);
        repeat (TMO - 1) cycle(0, 8'h00);
        cycle(0, 8'h00);
`ifdef S2P_TIMEOUT_EN
        chk("tmo_pulse", 32'(to16), 32'd1);
`else
        chk("tmo_pulse", 32'(to16), 32'd0);
`endif
        cycle(1, 8'hAA);
        cycle(1, 8'hBB);
`ifdef S2P_TIMEOUT_EN
        chk("tmo_word", 32'(word16), 32'h0000AABB);
`else
        chk("tmo_word", 32'(word16), 32'h000055AA);
`endif

        // Reset during a partial word
        do_reset();
        cycle(1, 8'h77);
        do_reset();
        cycle(1, 8'h01);
        cycle(1, 8'h02);
        chk("rst_word", 32'(word16), 32'h00000102);

        // 32-bit assembly with idle gaps
        do_reset();
        cycle(1, 8'hDE);
        repeat (3) cycle(0, 8'h00);
        cycle(1, 8'hAD);
        repeat (3) cycle(0, 8'h00);
        cycle(1, 8'hBE);
        repeat (3) cycle(0, 8'h00);
        cycle(1, 8'hEF);
        chk("w32_word", word32, 32'hDEADBEEF);
        chk("w32_valid", 32'(valid32), 32'd1);
        cycle(0, 8'h00);
        chk("w32_single", 32'(valid32), 32'd0);

        // Random traffic, stalls, silences and occasional resets
        for (int i = 0; i < 3000; i++) begin
            ready16 = ($urandom_range(0, 3) != 0);
            ready32 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 99) == 0) begin
                repeat ($urandom_range(TMO - 2, TMO + 2)) cycle(0, 8'h00);
            end else begin
                cycle($urandom_range(0, 99) < 45, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
